// File: rtl/neuron_acc_ctrl.sv
// Sequencing controller for the shared 10-bit RC adder in the integrate-and-fire neuron.
// Round-robin grants a weight, holds operands while the carry chain settles, then commits.
module neuron_acc_ctrl #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned SETTLE = 3,
  parameter int unsigned REFRAC = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [10*NREQ-1:0] req_w,
  output logic [NREQ-1:0]    req_ready,
  input  logic [9:0]         thr,
  output logic [9:0]         add_a,
  output logic [9:0]         add_b,
  output logic               add_cin,
  input  logic [9:0]         add_sum,
  input  logic               add_cout,
  output logic [9:0]         vmem,
  output logic               spike,
  output logic               busy
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned SumW = PtrW + 1;
  localparam int unsigned CntMax = (SETTLE > REFRAC) ? SETTLE : REFRAC;
  localparam int unsigned CntW = $clog2(CntMax + 1);

  typedef enum logic [2:0] {StIdle, StSettle, StCommit, StFire, StRefrac} state_e;

  state_e          state_q, state_d;
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [9:0]      vmem_q, vmem_d;
  logic [9:0]      wreg_q, wreg_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [PtrW-1:0]   off;
  logic [SumW-1:0]   sum;
  logic [PtrW-1:0]   gnt_idx;
  logic              gnt_any;
  logic [NREQ-1:0]   gnt_oh;
  logic [9:0]        w_sel;
  logic [9:0]        result;

  // Rotate valids so the pointer sits at bit 0; the lowest set bit is the winner.
  always_comb begin
    dbl = {req_valid, req_valid} >> ptr_q;
    rot = dbl[NREQ-1:0];
    off = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) off = PtrW'(k);
    end
    sum = {1'b0, ptr_q} + {1'b0, off};
    if (sum >= SumW'(NREQ)) sum = sum - SumW'(NREQ);
    gnt_idx = sum[PtrW-1:0];
    gnt_any = |req_valid;
    gnt_oh  = '0;
    w_sel   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == PtrW'(i)) begin
        gnt_oh[i] = gnt_any;
        w_sel     = req_w[10*i +: 10];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    vmem_d    = vmem_q;
    wreg_d    = wreg_q;
    cnt_d     = cnt_q;
    req_ready = '0;
    add_a     = '0;
    add_b     = '0;
    spike     = 1'b0;
    result    = add_cout ? 10'h3FF : add_sum;
    unique case (state_q)
      StIdle: begin
        if (gnt_any) begin
          req_ready = gnt_oh;
          wreg_d    = w_sel;
          ptr_d     = (gnt_idx == PtrW'(NREQ - 1)) ? '0 : gnt_idx + PtrW'(1);
          cnt_d     = '0;
          state_d   = StSettle;
        end
      end
      StSettle: begin
        add_a = vmem_q;
        add_b = wreg_q;
        if (cnt_q == CntW'(SETTLE - 1)) begin
          cnt_d   = '0;
          state_d = StCommit;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StCommit: begin
        add_a   = vmem_q;
        add_b   = wreg_q;
        vmem_d  = result;
        state_d = (result >= thr) ? StFire : StIdle;
      end
      StFire: begin
        spike   = 1'b1;
        vmem_d  = '0;
        cnt_d   = '0;
        state_d = StRefrac;
      end
      StRefrac: begin
        if (cnt_q == CntW'(REFRAC - 1)) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      vmem_q  <= '0;
      wreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      vmem_q  <= vmem_d;
      wreg_q  <= wreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign add_cin = 1'b0;
  assign vmem    = vmem_q;
  assign busy    = (state_q != StIdle);

endmodule
